// File: rtl/gpr_wb_scheduler_if.sv
// Bundle between decode / WB stage / MDU (master side) and the GPR write-port
// scheduler (slave side).
interface gpr_wb_scheduler_if;
  logic        iss_valid;
  logic [4:0]  iss_rs;
  logic [4:0]  iss_rt;
  logic [4:0]  iss_rd;
  logic        iss_rd_we;
  logic        iss_long;
  logic        issue_stall;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wd;
  logic        mdu_req;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_wd;
  logic        mdu_ack;
  logic        pipe_freeze;
  logic        gpr_we;
  logic [4:0]  gpr_rd;
  logic [31:0] gpr_wd;
  logic [31:0] pending;

  modport master (
    output iss_valid, iss_rs, iss_rt, iss_rd, iss_rd_we, iss_long,
    output wb_we, wb_rd, wb_wd,
    output mdu_req, mdu_rd, mdu_wd,
    input  issue_stall, mdu_ack, pipe_freeze,
    input  gpr_we, gpr_rd, gpr_wd, pending
  );

  modport slave (
    input  iss_valid, iss_rs, iss_rt, iss_rd, iss_rd_we, iss_long,
    input  wb_we, wb_rd, wb_wd,
    input  mdu_req, mdu_rd, mdu_wd,
    output issue_stall, mdu_ack, pipe_freeze,
    output gpr_we, gpr_rd, gpr_wd, pending
  );
endinterface

// File: rtl/gpr_wb_scheduler.sv
// GPR write-port owner: pipeline WB has priority, MDU results get a forced slot
// after STARVE_MAX refusals; MDU destinations are scoreboarded for RAW/WAW stalls.
// Optional write trace: define GPR_WB_TRACE_EN.
module gpr_wb_scheduler #(
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  gpr_wb_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FORCE = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state_q;
  logic [3:0]  starve_cnt_q;
  logic        freeze_q;
  logic        gpr_we_q;
  logic [4:0]  gpr_rd_q;
  logic [31:0] gpr_wd_q;
  logic [31:0] pending_q;
  logic [31:0] pending_d;

  logic        win_p;
  logic        win_m;
  logic        refuse;
  logic        force_go;
  logic [3:0]  cnt_inc;
  logic        accept;
  logic        stall;

  function automatic logic hit(input logic [4:0] r, input logic [31:0] p);
    return (r != 5'd0) && p[r];
  endfunction

  // Hazard detection against outstanding MDU destinations.
  always_comb begin
    stall  = bus.iss_valid &&
             (hit(bus.iss_rs, pending_q) || hit(bus.iss_rt, pending_q) ||
              (bus.iss_rd_we && hit(bus.iss_rd, pending_q)));
    accept = bus.iss_valid && !stall;
  end

  // Write-port arbitration for the current cycle.
  always_comb begin
    win_p    = 1'b0;
    win_m    = 1'b0;
    refuse   = 1'b0;
    force_go = 1'b0;
    cnt_inc  = starve_cnt_q + 4'd1;
    case (state_q)
      S_IDLE: begin
        win_p    = bus.wb_we;
        win_m    = bus.mdu_req && !bus.wb_we;
        refuse   = bus.mdu_req && bus.wb_we;
        force_go = refuse && (STARVE_LIM <= 4'd1);
      end
      S_WAIT: begin
        win_p    = bus.wb_we;
        win_m    = bus.mdu_req && !bus.wb_we;
        refuse   = bus.mdu_req && bus.wb_we;
        force_go = refuse && (cnt_inc >= STARVE_LIM);
      end
      S_FORCE: begin
        // WB stage is frozen and will re-present its write, so it is ignored here.
        win_m = bus.mdu_req;
      end
      default: begin
        win_p = 1'b0;
        win_m = 1'b0;
      end
    endcase
  end

  // Set wins over clear when the same register is granted and re-issued together.
  always_comb begin
    pending_d = pending_q;
    if (win_m) pending_d[bus.mdu_rd] = 1'b0;
    if (accept && bus.iss_long && bus.iss_rd_we && (bus.iss_rd != 5'd0))
      pending_d[bus.iss_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      starve_cnt_q <= 4'd0;
      freeze_q     <= 1'b0;
      gpr_we_q     <= 1'b0;
      gpr_rd_q     <= 5'd0;
      gpr_wd_q     <= 32'd0;
      pending_q    <= 32'd0;
    end else begin
      pending_q <= pending_d;
      gpr_we_q  <= win_p || win_m;
      if (win_m) begin
        gpr_rd_q <= bus.mdu_rd;
        gpr_wd_q <= bus.mdu_wd;
      end else if (win_p) begin
        gpr_rd_q <= bus.wb_rd;
        gpr_wd_q <= bus.wb_wd;
      end
      case (state_q)
        S_IDLE: begin
          if (refuse) begin
            starve_cnt_q <= 4'd1;
            state_q      <= force_go ? S_FORCE : S_WAIT;
            freeze_q     <= force_go;
          end
        end
        S_WAIT: begin
          if (refuse) begin
            starve_cnt_q <= cnt_inc;
            if (force_go) begin
              state_q  <= S_FORCE;
              freeze_q <= 1'b1;
            end
          end else begin
            starve_cnt_q <= 4'd0;
            state_q      <= S_IDLE;
          end
        end
        S_FORCE: begin
          starve_cnt_q <= 4'd0;
          freeze_q     <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: begin
          starve_cnt_q <= 4'd0;
          freeze_q     <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

`ifdef GPR_WB_TRACE_EN
  always @(posedge clk) begin
    if (!rst) begin
      if (win_m)
        $display("W[%2d]=%8X src=%s", bus.mdu_rd, bus.mdu_wd, "M");
      else if (win_p)
        $display("W[%2d]=%8X src=%s", bus.wb_rd, bus.wb_wd, "P");
      if (force_go)
        $display("STARVE");
    end
  end
`else
`endif

  // An in-flight grant is dropped while reset is held.
  assign bus.mdu_ack     = win_m && !rst;
  assign bus.issue_stall = stall;
  assign bus.pipe_freeze = freeze_q;
  assign bus.gpr_we      = gpr_we_q;
  assign bus.gpr_rd      = gpr_rd_q;
  assign bus.gpr_wd      = gpr_wd_q;
  assign bus.pending     = pending_q;

endmodule

// File: tb/tb_gpr_wb_scheduler.sv
// Directed bench for gpr_wb_scheduler: reset, hazards, priority, starvation,
// set/clear clash and reset during a forced MDU grant.
module tb_gpr_wb_scheduler;
  logic clk;
  logic rst;
  int   nchk;
  int   nerr;

  gpr_wb_scheduler_if bus ();

  gpr_wb_scheduler #(.STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic iss(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic we, input logic lng);
    bus.iss_valid = v;
    bus.iss_rs    = rs;
    bus.iss_rt    = rt;
    bus.iss_rd    = rd;
    bus.iss_rd_we = we;
    bus.iss_long  = lng;
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] wd);
    bus.wb_we = we;
    bus.wb_rd = rd;
    bus.wb_wd = wd;
  endtask

  task automatic mdu(input logic req, input logic [4:0] rd, input logic [31:0] wd);
    bus.mdu_req = req;
    bus.mdu_rd  = rd;
    bus.mdu_wd  = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nchk = 0;
    nerr = 0;
    rst  = 1'b1;
    iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    wb(1'b0, 5'd0, 32'd0);
    mdu(1'b0, 5'd0, 32'd0);
    tick();
    tick();
    chk("rst_gpr_we", 32'(bus.gpr_we), 32'd0);
    chk("rst_gpr_rd", 32'(bus.gpr_rd), 32'd0);
    chk("rst_gpr_wd", bus.gpr_wd, 32'd0);
    chk("rst_pending", bus.pending, 32'd0);
    chk("rst_freeze", 32'(bus.pipe_freeze), 32'd0);
    chk("rst_ack", 32'(bus.mdu_ack), 32'd0);
    rst = 1'b0;
    tick();

    // RAW on a long-latency destination
    iss(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
    #1 chk("long_issue_stall", 32'(bus.issue_stall), 32'd0);
    tick();
    chk("pend_r5", bus.pending, 32'h0000_0020);
    iss(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
    #1 chk("raw_rs_stall", 32'(bus.issue_stall), 32'd1);
    tick();
    chk("pend_r5_held", bus.pending, 32'h0000_0020);
    iss(1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
    #1 chk("raw_rt_stall", 32'(bus.issue_stall), 32'd1);
    iss(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1 chk("r0_src_nostall", 32'(bus.issue_stall), 32'd0);
    iss(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
    mdu(1'b1, 5'd5, 32'h0000_00AB);
    #1 chk("raw_mdu_ack", 32'(bus.mdu_ack), 32'd1);
    chk("raw_stall_ackcyc", 32'(bus.issue_stall), 32'd1);
    tick();
    chk("raw_wr_we", 32'(bus.gpr_we), 32'd1);
    chk("raw_wr_rd", 32'(bus.gpr_rd), 32'd5);
    chk("raw_wr_wd", bus.gpr_wd, 32'h0000_00AB);
    chk("raw_pend_clr", bus.pending, 32'd0);
    mdu(1'b0, 5'd0, 32'd0);
    #1 chk("raw_stall_released", 32'(bus.issue_stall), 32'd0);

    // Long op to R0 is never scoreboarded
    iss(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    tick();
    chk("r0_never_pending", bus.pending, 32'd0);
    iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    chk("idle_no_write", 32'(bus.gpr_we), 32'd0);

    // Pipeline WB wins over MDU
    wb(1'b1, 5'd3, 32'h11);
    mdu(1'b1, 5'd4, 32'h22);
    #1 chk("prio_no_ack", 32'(bus.mdu_ack), 32'd0);
    tick();
    chk("prio_wr_rd", 32'(bus.gpr_rd), 32'd3);
    chk("prio_wr_wd", bus.gpr_wd, 32'h11);
    wb(1'b0, 5'd3, 32'h11);
    #1 chk("prio_ack_after", 32'(bus.mdu_ack), 32'd1);
    tick();
    chk("prio_mdu_rd", 32'(bus.gpr_rd), 32'd4);
    chk("prio_mdu_wd", bus.gpr_wd, 32'h22);
    mdu(1'b0, 5'd0, 32'd0);
    tick();
    chk("prio_quiet", 32'(bus.gpr_we), 32'd0);

    // Starvation: four refusals then a forced MDU slot
    wb(1'b1, 5'd3, 32'h11);
    mdu(1'b1, 5'd4, 32'h22);
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("starve_noack%0d", i), 32'(bus.mdu_ack), 32'd0);
      tick();
      chk($sformatf("starve_freeze%0d", i), 32'(bus.pipe_freeze), (i == 3) ? 32'd1 : 32'd0);
      chk($sformatf("starve_wbwr%0d", i), 32'(bus.gpr_rd), 32'd3);
    end
    #1 chk("force_ack", 32'(bus.mdu_ack), 32'd1);
    tick();
    chk("force_wr_rd", 32'(bus.gpr_rd), 32'd4);
    chk("force_wr_wd", bus.gpr_wd, 32'h22);
    chk("force_freeze_drop", 32'(bus.pipe_freeze), 32'd0);
    mdu(1'b0, 5'd0, 32'd0);
    tick();
    chk("post_force_wb", 32'(bus.gpr_rd), 32'd3);
    wb(1'b0, 5'd0, 32'd0);
    tick();

    // Set/clear clash on R7
    mdu(1'b1, 5'd7, 32'h77);
    iss(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
    #1 chk("clash_ack", 32'(bus.mdu_ack), 32'd1);
    chk("clash_nostall", 32'(bus.issue_stall), 32'd0);
    tick();
    chk("clash_set_wins", bus.pending, 32'h0000_0080);
    chk("clash_wr_rd", 32'(bus.gpr_rd), 32'd7);
    iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    chk("clash_clear", bus.pending, 32'd0);
    mdu(1'b0, 5'd0, 32'd0);

    // WAW on R9
    iss(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
    tick();
    chk("waw_pend", bus.pending, 32'h0000_0200);
    iss(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
    #1 chk("waw_stall", 32'(bus.issue_stall), 32'd1);
    iss(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0);
    #1 chk("waw_nowe_nostall", 32'(bus.issue_stall), 32'd0);
    iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // Reset asserted while in FORCE
    wb(1'b1, 5'd3, 32'h11);
    mdu(1'b1, 5'd9, 32'h99);
    repeat (4) tick();
    chk("pre_rst_freeze", 32'(bus.pipe_freeze), 32'd1);
    #2 rst = 1'b1;
    wb(1'b0, 5'd3, 32'h11);
    #1 chk("arst_freeze", 32'(bus.pipe_freeze), 32'd0);
    chk("arst_pending", bus.pending, 32'd0);
    chk("arst_gpr_we", 32'(bus.gpr_we), 32'd0);
    chk("arst_gpr_rd", 32'(bus.gpr_rd), 32'd0);
    chk("arst_gpr_wd", bus.gpr_wd, 32'd0);
    chk("arst_no_ack", 32'(bus.mdu_ack), 32'd0);
    tick();
    rst = 1'b0;
    #1 chk("rereq_ack", 32'(bus.mdu_ack), 32'd1);
    tick();
    chk("rereq_wr_rd", 32'(bus.gpr_rd), 32'd9);
    chk("rereq_wr_wd", bus.gpr_wd, 32'h99);
    mdu(1'b0, 5'd0, 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
